lif_array: RTL and testbench

- Parametrised array of N_CH leaky integrate-and-fire neurons with adaptive thresholds, per-channel refractory period and per-channel enables.
- Neuron state advances only on a global timestep strobe, which decouples the neuron time constant from the system clock.
- Sits between the input current encoder and downstream spike consumers (router/readout).
- Also provides an aggregate spike flag and a saturating spike counter for monitoring.

---
 rtl/lif_pkg.sv | 36 +++
 rtl/lif_core.sv | 86 ++++++++
 rtl/lif_array.sv | 86 ++++++++
 tb/tb_lif_array.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

  // Per-channel state layout; lif_core requires its WIDTH_P and REFRACT_PRD to fit it.
  localparam int unsigned LIF_WIDTH   = 8;
  localparam int unsigned LIF_REFRACT = 3;
  localparam int unsigned LIF_REF_W   =
      ($clog2(LIF_REFRACT + 1) > 0) ? $clog2(LIF_REFRACT + 1) : 1;

  typedef struct packed {
    logic [LIF_WIDTH-1:0] v;
    logic [LIF_WIDTH-1:0] thr;
    logic [LIF_REF_W-1:0] ref_cnt;
  } lif_state_t;

  // Unsigned add of two w-bit operands, clamped to 2^w-1 using the carry out.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? 32'(lim) : 32'(sum);
  endfunction

  // Number of set bits in a vector of up to 32 flags.
  function automatic int unsigned popcount(input logic [31:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lif_core.sv
// Single leaky integrate-and-fire neuron with adaptive threshold and refractory period.
module lif_core
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH_P       = 8,
  parameter int unsigned THRESHOLD     = 64,
  parameter int unsigned THRESHOLD_INC = 4,
  parameter int unsigned THRESHOLD_DEC = 2,
  parameter int unsigned THRESHOLD_MIN = 32,
  parameter int unsigned REFRACT_PRD   = 3,
  parameter int unsigned LEAK_ACT      = 1,
  parameter int unsigned LEAK_IDLE     = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               en_i,
  input  logic [WIDTH_P-1:0] current_i,
  output logic               spike_o,
  output logic               spike_next_o
);

  if (WIDTH_P != LIF_WIDTH) begin : g_bad_width
    $error("lif_core: WIDTH_P must equal lif_pkg::LIF_WIDTH");
  end
  if ($clog2(REFRACT_PRD + 1) > LIF_REF_W) begin : g_bad_refract
    $error("lif_core: REFRACT_PRD does not fit lif_pkg::LIF_REF_W");
  end

  localparam logic [WIDTH_P-1:0]   ThrRst  = WIDTH_P'(THRESHOLD);
  localparam logic [WIDTH_P-1:0]   ThrMin  = WIDTH_P'(THRESHOLD_MIN);
  localparam logic [WIDTH_P-1:0]   ThrDec  = WIDTH_P'(THRESHOLD_DEC);
  localparam logic [LIF_REF_W-1:0] RefLoad = LIF_REF_W'(REFRACT_PRD);

  lif_state_t         state_q, state_d;
  logic               spike_q, spike_d;
  logic [WIDTH_P-1:0] v_act, v_idle, v_next, thr_up, thr_down;

  // Candidate values for the potential and threshold, then the per-tick state update.
  always_comb begin
    v_act  = WIDTH_P'(sat_add(32'(current_i), 32'(state_q.v >> LEAK_ACT), WIDTH_P));
    v_idle = state_q.v - (state_q.v >> LEAK_IDLE);
    v_next = (current_i != '0) ? v_act : v_idle;

    thr_up = WIDTH_P'(sat_add(32'(state_q.thr), THRESHOLD_INC, WIDTH_P));
    if (state_q.thr > ThrMin) begin
      thr_down = (32'(state_q.thr - ThrMin) > THRESHOLD_DEC) ? state_q.thr - ThrDec : ThrMin;
    end else begin
      thr_down = state_q.thr;
    end

    state_d = state_q;
    spike_d = 1'b0;
    if (tick_i && en_i) begin
      if (state_q.ref_cnt != '0) begin
        // Refractory: input ignored, threshold keeps relaxing.
        state_d.v       = '0;
        state_d.ref_cnt = state_q.ref_cnt - LIF_REF_W'(1);
        state_d.thr     = thr_down;
      end else if (v_next >= state_q.thr) begin
        spike_d         = 1'b1;
        state_d.v       = '0;
        state_d.ref_cnt = RefLoad;
        state_d.thr     = thr_up;
      end else begin
        state_d.v   = v_next;
        state_d.thr = thr_down;
      end
    end
  end

  // Neuron state and spike register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '{v: '0, thr: ThrRst, ref_cnt: '0};
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o      = spike_q;
  assign spike_next_o = spike_d;

endmodule

// File: rtl/lif_array.sv
// Array of N_CH LIF neurons sharing a timestep strobe, with spike OR and saturating counter.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned WIDTH_P       = LIF_WIDTH,
  parameter int unsigned THRESHOLD     = 64,
  parameter int unsigned THRESHOLD_INC = 4,
  parameter int unsigned THRESHOLD_DEC = 2,
  parameter int unsigned THRESHOLD_MIN = 32,
  parameter int unsigned REFRACT_PRD   = LIF_REFRACT,
  parameter int unsigned LEAK_ACT      = 1,
  parameter int unsigned LEAK_IDLE     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      tick_i,
  input  logic [N_CH-1:0]           en_i,
  input  logic [N_CH*WIDTH_P-1:0]   current_i,
  input  logic                      cnt_clr_i,
  output logic [N_CH-1:0]           spike_o,
  output logic                      spike_any_o,
  output logic [CNT_W-1:0]          spike_cnt_o
);

  if ((THRESHOLD_MIN > THRESHOLD) || (THRESHOLD > (1 << WIDTH_P) - 1)) begin : g_bad_thr
    $error("lif_array: need THRESHOLD_MIN <= THRESHOLD <= 2^WIDTH_P-1");
  end
  if ((LEAK_ACT >= WIDTH_P) || (LEAK_IDLE >= WIDTH_P)) begin : g_bad_leak
    $error("lif_array: leak shifts must be smaller than WIDTH_P");
  end
  if ((N_CH < 1) || (N_CH > 32) || (CNT_W < 1) || (CNT_W > 32)) begin : g_bad_size
    $error("lif_array: N_CH and CNT_W must be within 1..32");
  end

  logic [N_CH-1:0]  spike_next;
  logic             spike_any_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    lif_core #(
      .WIDTH_P      (WIDTH_P),
      .THRESHOLD    (THRESHOLD),
      .THRESHOLD_INC(THRESHOLD_INC),
      .THRESHOLD_DEC(THRESHOLD_DEC),
      .THRESHOLD_MIN(THRESHOLD_MIN),
      .REFRACT_PRD  (REFRACT_PRD),
      .LEAK_ACT     (LEAK_ACT),
      .LEAK_IDLE    (LEAK_IDLE)
    ) u_core (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tick_i      (tick_i),
      .en_i        (en_i[k]),
      .current_i   (current_i[k*WIDTH_P +: WIDTH_P]),
      .spike_o     (spike_o[k]),
      .spike_next_o(spike_next[k])
    );
  end

  // Counter accumulates the spikes currently on spike_o; clear discards them.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = CNT_W'(sat_add(32'(cnt_q), popcount(32'(spike_o)), CNT_W));
    end
  end

  // OR is taken from the next-state spikes so it lines up with the registered spike_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spike_any_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      spike_any_q <= |spike_next;
      cnt_q       <= cnt_d;
    end
  end

  assign spike_any_o = spike_any_q;
  assign spike_cnt_o = cnt_q;

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: per-cycle model comparison plus directed literal checks.
module tb_lif_array;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        cnt_clr;
  logic [3:0]  en;
  logic [7:0]  cur [N];
  logic [31:0] current_bus;

  logic [3:0]  spike, spike4;
  logic        any, any4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  logic [7:0]  dv   [N];
  logic [7:0]  dthr [N];
  logic [1:0]  dref [N];

  int  n_total = 0;
  int  n_pass  = 0;
  bit  chk_en  = 0;

  assign current_bus = {cur[3], cur[2], cur[1], cur[0]};

  lif_array dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .en_i       (en),
    .current_i  (current_bus),
    .cnt_clr_i  (cnt_clr),
    .spike_o    (spike),
    .spike_any_o(any),
    .spike_cnt_o(cnt)
  );

  lif_array #(.CNT_W(4)) dut4 (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .en_i       (en),
    .current_i  (current_bus),
    .cnt_clr_i  (cnt_clr),
    .spike_o    (spike4),
    .spike_any_o(any4),
    .spike_cnt_o(cnt4)
  );

  for (genvar g = 0; g < N; g++) begin : g_peek
    assign dv[g]   = dut.g_ch[g].u_core.state_q.v;
    assign dthr[g] = dut.g_ch[g].u_core.state_q.thr;
    assign dref[g] = dut.g_ch[g].u_core.state_q.ref_cnt;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         m_v   [N];
  int         m_thr [N];
  int         m_ref [N];
  logic [3:0] m_spk;
  logic       m_any;
  int         m_cnt16;
  int         m_cnt4;

  function automatic int relax(input int t);
    if (t <= 32) return t;
    return (t - 2 < 32) ? 32 : t - 2;
  endfunction

  always @(posedge clk) begin
    int vn, nv, nthr, nref, pc;
    logic [3:0] sn;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_v[k]   <= 0;
        m_thr[k] <= 64;
        m_ref[k] <= 0;
      end
      m_spk   <= '0;
      m_any   <= 1'b0;
      m_cnt16 <= 0;
      m_cnt4  <= 0;
    end else begin
      pc = 0;
      for (int k = 0; k < N; k++) if (m_spk[k]) pc++;
      m_cnt16 <= cnt_clr ? 0 : ((m_cnt16 + pc > 65535) ? 65535 : m_cnt16 + pc);
      m_cnt4  <= cnt_clr ? 0 : ((m_cnt4 + pc > 15) ? 15 : m_cnt4 + pc);
      sn = '0;
      for (int k = 0; k < N; k++) begin
        nv   = m_v[k];
        nthr = m_thr[k];
        nref = m_ref[k];
        if (tick && en[k]) begin
          if (m_ref[k] > 0) begin
            nv   = 0;
            nref = m_ref[k] - 1;
            nthr = relax(m_thr[k]);
          end else begin
            if (cur[k] != 0) vn = int'(cur[k]) + m_v[k] / 2;
            else             vn = m_v[k] - m_v[k] / 8;
            if (vn > 255) vn = 255;
            if (vn >= m_thr[k]) begin
              sn[k] = 1'b1;
              nv    = 0;
              nref  = 3;
              nthr  = (m_thr[k] + 4 > 255) ? 255 : m_thr[k] + 4;
            end else begin
              nv   = vn;
              nthr = relax(m_thr[k]);
            end
          end
        end
        m_v[k]   <= nv;
        m_thr[k] <= nthr;
        m_ref[k] <= nref;
      end
      m_spk <= sn;
      m_any <= |sn;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("spike_o", int'(spike), int'(m_spk));
      check("spike_any_o", int'(any), int'(m_any));
      check("spike_cnt_o", int'(cnt), m_cnt16);
      check("spike_o cnt4", int'(spike4), int'(m_spk));
      check("spike_any_o cnt4", int'(any4), int'(m_any));
      check("spike_cnt_o cnt4", int'(cnt4), m_cnt4);
      for (int k = 0; k < N; k++) begin
        check($sformatf("v[%0d]", k), int'(dv[k]), m_v[k]);
        check($sformatf("thr[%0d]", k), int'(dthr[k]), m_thr[k]);
        check($sformatf("ref_cnt[%0d]", k), int'(dref[k]), m_ref[k]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) clk_step();
  endtask

  task automatic tick_once();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; tick = 1'b0; cnt_clr = 1'b0; en = '0;
    for (int k = 0; k < N; k++) cur[k] = 8'd0;
    clk_step();
    chk_en = 1;
    clk_step();
    check("reset spike_o", int'(spike), 0);
    check("reset cnt", int'(cnt), 0);
    check("reset v0", int'(dv[0]), 0);
    check("reset thr0", int'(dthr[0]), 64);
    rst = 1'b0;

    // tick 1
    en = 4'hF;
    cur[0] = 8'd40; cur[1] = 8'd50; cur[2] = 8'd40; cur[3] = 8'd40;
    tick_once();
    check("t1 v0", int'(dv[0]), 40);
    check("t1 thr0", int'(dthr[0]), 62);
    check("t1 v1", int'(dv[1]), 50);
    check("t1 v3", int'(dv[3]), 40);
    idle(3);

    // tick 2: ch2 saturates, ch3 disabled for 5 ticks
    cur[1] = 8'd0; cur[2] = 8'd255; en = 4'b0111;
    tick_once();
    check("t2 v0", int'(dv[0]), 60);
    check("t2 thr0", int'(dthr[0]), 60);
    check("t2 v1", int'(dv[1]), 44);
    check("t2 sat spike", int'(spike), 4'b0100);
    check("t2 thr2", int'(dthr[2]), 66);
    clk_step();
    check("t2 spike width", int'(spike), 0);
    idle(2);

    // tick 3: ch0 fires
    cur[2] = 8'd0;
    tick_once();
    check("t3 v0", int'(dv[0]), 0);
    check("t3 thr0", int'(dthr[0]), 64);
    check("t3 spike", int'(spike), 4'b0001);
    check("t3 v1", int'(dv[1]), 39);
    check("t3 thr1", int'(dthr[1]), 58);
    clk_step();
    check("t3 spike width", int'(spike[0]), 0);
    idle(2);

    // ticks 4-6: ch0 refractory
    for (int i = 1; i <= 3; i++) begin
      tick_once();
      check("refr v0", int'(dv[0]), 0);
      check("refr thr0", int'(dthr[0]), 64 - 2 * i);
      check("refr spike0", int'(spike[0]), 0);
      idle(3);
    end
    check("hold v3", int'(dv[3]), 40);
    check("hold thr3", int'(dthr[3]), 62);
    check("hold ref3", int'(dref[3]), 0);

    // tick 7: ch0 integrates again, ch3 resumes
    en = 4'hF;
    tick_once();
    check("t7 v0", int'(dv[0]), 40);
    check("t7 thr0", int'(dthr[0]), 56);
    check("t7 v3", int'(dv[3]), 60);
    check("t7 thr3", int'(dthr[3]), 60);
    check("t7 v1", int'(dv[1]), 25);
    check("t7 thr1", int'(dthr[1]), 50);
    idle(1);

    // ch1 threshold decays to the floor
    en = 4'b0010;
    repeat (12) begin
      tick_once();
      idle(1);
    end
    check("thr1 floor", int'(dthr[1]), 32);

    // reset while ch0 is refractory with a spike on the output
    en = 4'b0001;
    tick_once();
    check("pre-rst spike0", int'(spike[0]), 1);
    check("pre-rst ref0", int'(dref[0]), 3);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    check("rst v0", int'(dv[0]), 0);
    check("rst thr0", int'(dthr[0]), 64);
    check("rst ref0", int'(dref[0]), 0);
    check("rst spike", int'(spike), 0);
    check("rst cnt", int'(cnt), 0);

    // all channels fire repeatedly under a continuous tick
    en = 4'hF;
    for (int k = 0; k < N; k++) cur[k] = 8'd255;
    tick = 1'b1;
    idle(40);
    check("cnt4 sat", int'(cnt4), 15);
    check("cnt16 total", int'(cnt), 40);

    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (spike == 4'hF) found = 1;
      else clk_step();
    end
    check("align on 4 spikes", int'(found), 1);
    cnt_clr = 1'b1;
    clk_step();
    cnt_clr = 1'b0;
    check("clr cnt16", int'(cnt), 0);
    check("clr cnt4", int'(cnt4), 0);
    tick = 1'b0;
    idle(4);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
